// File: rtl/sr_latch_driver_pkg.sv
// Shared definitions for the gated SR latch write controller: state encoding,
// default timing constants and the feedback-agreement helper.
package sr_latch_driver_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDrive  = 2'd1,
    StSettle = 2'd2,
    StCheck  = 2'd3
  } state_e;

  localparam int unsigned DefPulseCycles  = 2;
  localparam int unsigned DefSettleCycles = 3;
  localparam int unsigned DefCntW         = 4;

  // True when the latch outputs are complementary and Q equals the value.
  function automatic logic fb_holds(input logic q, input logic qb, input logic v);
    return (q == v) && (qb == !v);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchronizer with asynchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/sr_latch_driver.sv
// Write controller for a gated SR latch: turns a one-bit request into an
// S/R/enable pulse, waits for the latch to settle, then verifies read-back.
module sr_latch_driver
  import sr_latch_driver_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES  = DefPulseCycles,
  parameter int unsigned SETTLE_CYCLES = DefSettleCycles,
  parameter int unsigned CNT_W         = DefCntW
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic Req_valid,
  input  logic Req_data,
  output logic Req_ready,
  output logic S,
  output logic R,
  output logic Latch_en,
  input  logic Q_fb,
  input  logic Q_bar_fb,
  output logic Done,
  output logic Match,
  output logic Err,
  input  logic Err_clr
);

  localparam logic [CNT_W-1:0] PulseLoad  = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SettleLoad = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             d;
  logic             qs;
  logic             qbs;
  logic             hold_now;
  logic             rb_ok;

  sync_2ff u_sync_q (
    .clk   (Clk),
    .rst_n (Rst_n),
    .d     (Q_fb),
    .q     (qs)
  );

  sync_2ff u_sync_qb (
    .clk   (Clk),
    .rst_n (Rst_n),
    .d     (Q_bar_fb),
    .q     (qbs)
  );

  assign Req_ready = (state == StIdle);
  assign hold_now  = fb_holds(qs, qbs, Req_data);
  assign rb_ok     = fb_holds(qs, qbs, d);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= StIdle;
      cnt      <= '0;
      d        <= 1'b0;
      S        <= 1'b0;
      R        <= 1'b0;
      Latch_en <= 1'b0;
      Done     <= 1'b0;
      Match    <= 1'b0;
      Err      <= 1'b0;
    end else begin
      Done  <= 1'b0;
      Match <= 1'b0;
      // A mismatch assignment later in this block overrides the clear.
      if (Err_clr) Err <= 1'b0;
      case (state)
        StIdle: begin
          if (Req_valid) begin
            d <= Req_data;
            if (hold_now) begin
              // Latch already holds the value: report without pulsing.
              state <= StCheck;
              cnt   <= '0;
              Done  <= 1'b1;
              Match <= 1'b1;
            end else begin
              state    <= StDrive;
              cnt      <= PulseLoad;
              Latch_en <= 1'b1;
              S        <= Req_data;
              R        <= !Req_data;
            end
          end
        end
        StDrive: begin
          if (cnt == '0) begin
            state    <= StSettle;
            cnt      <= SettleLoad;
            Latch_en <= 1'b0;
            S        <= 1'b0;
            R        <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        StSettle: begin
          if (cnt == '0) begin
            state <= StCheck;
            Done  <= 1'b1;
            Match <= rb_ok;
            if (!rb_ok) Err <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        StCheck: begin
          state <= StIdle;
          cnt   <= '0;
        end
        default: begin
          state <= StIdle;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
